branch_predictor: RTL and testbench
===================================

# branch_predictor

Two-bit saturating-counter branch history table for the five-stage pipelined MIPS CPU. The IF stage looks up the fetch PC and receives a taken/not-taken prediction plus the raw 2-bit counter state. The counter state travels down the pipe in the IF/ID and ID/EX two-bit pipeline registers. The EX stage returns the resolved outcome to train the table, and the block flags mispredictions to the flush logic.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries by default)
- PC_WIDTH, 32, width of PC inputs

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears table and all registered outputs
- lookup_en  in  1  IF-stage lookup is valid this cycle; low during IF stall
- lookup_pc  in  PC_WIDTH  fetch PC to predict
- pred_state  out  2  counter value at lookup index; feeds the IF/ID two-bit register
- pred_taken  out  1  pred_state[1]
- upd_valid  in  1  EX stage has a resolved conditional branch this cycle
- upd_pc  in  PC_WIDTH  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_pred_taken  in  1  prediction originally made for this branch, carried down the pipe
- mispredict  out  1  registered one-cycle pulse on wrong prediction
- stat_lookups  out  16  lookup counter; present only with the statistics feature
- stat_mispredicts  out  16  mispredict counter; present only with the statistics feature

## Operation
- Index: lookup_pc[INDEX_BITS+1:2] and upd_pc[INDEX_BITS+1:2]. PCs are word-aligned, so bits [1:0] are ignored. Upper bits are not tagged, and aliasing is accepted.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Read: pred_state is a combinational read of table[lookup index]. It is independent of lookup_en; lookup_en only gates the statistics.
- Update on upd_valid:
  - upd_taken=1: increment, saturating at 11.
  - upd_taken=0: decrement, saturating at 00.
  - Only the indexed entry changes.
- mispredict: registered value of upd_valid & (upd_taken != upd_pred_taken).
- Reset: every entry becomes 01, mispredict becomes 0, and statistics become 0, all within the single reset cycle.
  - Reset dominates: upd_valid asserted during reset is discarded.
  - A reset mid-training loses all history.

## Timing
- Lookup latency: 0 cycles (combinational from lookup_pc).
- Update: table entry written at the rising edge where upd_valid=1. The new value is visible to lookups from the next cycle.
- Same-cycle read/write of the same index returns the old value. There is no bypass.
- mispredict: high for exactly the one cycle after the update edge. Back-to-back updates give back-to-back pulses.
- First cycle after reset deasserts: lookups return 01 and pred_taken=0.

## Configuration
- BP_STATS_EN defined:
  - stat_lookups increments on every non-reset cycle with lookup_en=1.
  - stat_mispredicts increments on every cycle where the mispredict condition is computed true.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- BP_STATS_EN undefined: both counters and their ports are omitted. All other behaviour is identical.

## Test plan
- Reset, then look up pc 0x00, 0x40 and 0xFC. Required: pred_state=01 and pred_taken=0 for each; mispredict=0.
- Three upd_valid/upd_taken=1 updates to pc 0x40. Required: lookup of 0x40 reads 10, then 11, then stays 11. A following single not-taken update reads 10. Entries other than index 16 stay 01.
- Aliasing: train pc 0x40 to 11, then look up 0x140 (also index 16). Required: 11. Two not-taken updates to 0x140 bring lookup of 0x40 to 01.
- Same-cycle read/write: lookup_pc=upd_pc=0x80, entry=01, upd_taken=1. Required: pred_state=01 that cycle and 10 the next cycle.
- Mispredict: upd_pred_taken=0, upd_taken=1 at edge N. Required: mispredict=1 during cycle N+1 only. With BP_STATS_EN, stat_mispredicts goes 0→1.
- Reset mid-operation: train index 16 to 11, then assert reset in the same cycle as upd_valid (not-taken) to 0x40. Required: entry=01 after reset, mispredict=0, stats=0.

Source files
------------

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch history table with registered mispredict flag.
// Define BP_STATS_EN to add the saturating lookup/mispredict statistics counters and ports.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookup_en,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic [1:0]          pred_state,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_pred_taken,
`ifdef BP_STATS_EN
  output logic [15:0]         stat_lookups,
  output logic [15:0]         stat_mispredicts,
`endif
  output logic                mispredict
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [1:0]            table_q [ENTRIES];
  logic [1:0]            table_d [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  mispredict_d;
  logic                  mispredict_q;
  logic                  mis_cond;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign upd_idx    = upd_pc[INDEX_BITS+1:2];

  // Untagged table: upper PC bits and byte offset deliberately do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

  // No write-to-read bypass: a same-cycle update is seen only from the next cycle.
  assign pred_state = table_q[lookup_idx];
  assign pred_taken = pred_state[1];

  assign mis_cond = upd_valid & (upd_taken != upd_pred_taken);

  always_comb begin
    table_d = table_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (table_q[upd_idx] != CTR_STRONG_T) table_d[upd_idx] = table_q[upd_idx] + 2'd1;
      end else begin
        if (table_q[upd_idx] != CTR_STRONG_NT) table_d[upd_idx] = table_q[upd_idx] - 2'd1;
      end
    end
  end

  assign mispredict_d = mis_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_WEAK_NT;
      mispredict_q <= 1'b0;
    end else begin
      table_q      <= table_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign mispredict = mispredict_q;

`ifdef BP_STATS_EN
  logic [15:0] stat_lookups_d;
  logic [15:0] stat_lookups_q;
  logic [15:0] stat_mispredicts_d;
  logic [15:0] stat_mispredicts_q;

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (lookup_en && (stat_lookups_q != 16'hFFFF)) stat_lookups_d = stat_lookups_q + 16'd1;
    if (mis_cond && (stat_mispredicts_q != 16'hFFFF)) stat_mispredicts_d = stat_mispredicts_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups_q     <= 16'd0;
      stat_mispredicts_q <= 16'd0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a per-cycle expectation queue fed by an
// abstract counter-table model, plus direct checks of the documented scenarios.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic [1:0]  pred_state;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispredicts;
`endif

  branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_en      (lookup_en),
    .lookup_pc      (lookup_pc),
    .pred_state     (pred_state),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
`ifdef BP_STATS_EN
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts),
`endif
    .mispredict     (mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int mis;
    int sl;
    int sm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a plain array of counters 0..3 plus event tallies.
  int model_tab [64];
  int mis_exp;
  int n_look;
  int n_mis;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_tab[i] = 1;
    mis_exp = 0;
    n_look  = 0;
    n_mis   = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic len, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic upt);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    lookup_en      = len;
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_pred_taken = upt;
    e.st = model_tab[idx_of(lpc)];
    e.mis = mis_exp;
    e.sl = n_look;
    e.sm = n_mis;
    sb.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      if (uv) begin
        if (ut) model_tab[idx_of(upc)] = (model_tab[idx_of(upc)] >= 3) ? 3 : model_tab[idx_of(upc)] + 1;
        else    model_tab[idx_of(upc)] = (model_tab[idx_of(upc)] <= 0) ? 0 : model_tab[idx_of(upc)] - 1;
      end
      mis_exp = (uv && (ut != upt)) ? 1 : 0;
      if (len && n_look < 65535) n_look++;
      if (mis_exp == 1 && n_mis < 65535) n_mis++;
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(1'b0, 1'b1, lpc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic ut);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, pc, ut, ut);
  endtask

  task automatic direct_state(input string name, input int exp);
    @(negedge clk);
    check(name, int'(pred_state), exp);
  endtask

  task automatic direct_mis(input string name, input int exp);
    @(negedge clk);
    check(name, int'(mispredict), exp);
  endtask

  // Monitor: the DUT presents pred_state/mispredict every cycle; one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_pred_state", int'(pred_state), e.st);
        check("sb_pred_taken", int'(pred_taken), e.st / 2);
        check("sb_mispredict", int'(mispredict), e.mis);
`ifdef BP_STATS_EN
        check("sb_stat_lookups", int'(stat_lookups), e.sl);
        check("sb_stat_mispredicts", int'(stat_mispredicts), e.sm);
`endif
      end
    end
  end

  initial begin
    logic [31:0] pool [4];
    logic [31:0] lpc_r;
    logic [31:0] upc_r;
    reset = 1'b1; lookup_en = 1'b0; lookup_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Post-reset lookups
    cycle(1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    direct_state("reset_pc00", 1);
    direct_mis("reset_mis", 0);
    idle(32'h40);
    direct_state("reset_pc40", 1);
    idle(32'hFC);
    direct_state("reset_pcFC", 1);

    // Saturating training of index 16
    upd(32'h40, 1'b1);
    idle(32'h40);
    direct_state("train_10", 2);
    upd(32'h40, 1'b1);
    idle(32'h40);
    direct_state("train_11", 3);
    upd(32'h40, 1'b1);
    idle(32'h40);
    direct_state("train_sat11", 3);
    upd(32'h40, 1'b0);
    idle(32'h40);
    direct_state("train_dec10", 2);
    idle(32'h44);
    direct_state("other_entry", 1);

    // Aliasing via 0x140
    upd(32'h40, 1'b1);
    idle(32'h140);
    direct_state("alias_11", 3);
    upd(32'h140, 1'b0);
    upd(32'h140, 1'b0);
    idle(32'h40);
    direct_state("alias_01", 1);

    // Same-cycle read/write without bypass
    cycle(1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1);
    direct_state("rw_old", 1);
    idle(32'h80);
    direct_state("rw_new", 2);

    // Mispredict pulse
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, 1'b0);
    direct_mis("mis_edge_cycle", 0);
    idle(32'h0);
    direct_mis("mis_pulse", 1);
    idle(32'h0);
    direct_mis("mis_clear", 0);

    // Reset mid-operation with a coincident update
    upd(32'h40, 1'b1);
    upd(32'h40, 1'b1);
    cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1);
    idle(32'h40);
    direct_state("midreset_entry", 1);
    direct_mis("midreset_mis", 0);

    // Randomized traffic over a small, aliasing-prone PC pool
    pool[0] = 32'h40; pool[1] = 32'h140; pool[2] = 32'h80; pool[3] = 32'h0;
    for (int i = 0; i < 400; i++) begin
      pool[3] = $urandom() & 32'hFFFF_FFFC;
      lpc_r = pool[$urandom_range(0, 3)];
      upc_r = pool[$urandom_range(0, 3)];
      cycle(($urandom_range(0, 49) == 0), 1'($urandom()), lpc_r,
            1'($urandom()), upc_r, 1'($urandom()), 1'($urandom()));
    end
    idle(32'h0);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
